// File: rtl/id_ex_alu_stage.sv
// ============================================================================
//  Module      : id_ex_alu_stage
//  Description : ID/EX pipeline register with ALU-control decode for RV32.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_alu_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [2:0]            id_funct3,
  input  logic                  id_funct7_5,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_a,
  output logic [XLEN-1:0]       ex_b,
  output logic                  ex_ainvert,
  output logic                  ex_binvert,
  output logic [1:0]            ex_operation,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_is_branch,
  output logic                  ex_illegal,
  output logic [15:0]           ex_bubble_cnt
);

  localparam logic [6:0]  c_opc_r      = 7'b0110011;
  localparam logic [6:0]  c_opc_i      = 7'b0010011;
  localparam logic [6:0]  c_opc_load   = 7'b0000011;
  localparam logic [6:0]  c_opc_store  = 7'b0100011;
  localparam logic [6:0]  c_opc_branch = 7'b1100011;
  localparam logic [1:0]  c_alu_and    = 2'b00;
  localparam logic [1:0]  c_alu_or     = 2'b01;
  localparam logic [1:0]  c_alu_add    = 2'b10;
  localparam logic [1:0]  c_alu_less   = 2'b11;
  localparam logic [15:0] c_cnt_max    = 16'hFFFF;

  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       a_q, a_d;
  logic [XLEN-1:0]       b_q, b_d;
  logic                  ainvert_q, ainvert_d;
  logic                  binvert_q, binvert_d;
  logic [1:0]            operation_q, operation_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  reg_write_q, reg_write_d;
  logic                  is_branch_q, is_branch_d;
  logic                  illegal_q, illegal_d;
  logic [15:0]           bubble_cnt_q, bubble_cnt_d;

  logic       w_binv;
  logic [1:0] w_op;
  logic       w_use_imm;
  logic       w_wr;
  logic       w_br;
  logic       w_ill;

  // R-type and I-ALU share the funct3 table; SUB only exists for R-type.
  always_comb begin
    w_binv    = 1'b0;
    w_op      = c_alu_add;
    w_use_imm = 1'b0;
    w_wr      = 1'b0;
    w_br      = 1'b0;
    w_ill     = 1'b0;
    case (id_opcode)
      c_opc_r, c_opc_i: begin
        w_wr      = 1'b1;
        w_use_imm = (id_opcode == c_opc_i);
        case (id_funct3)
          3'b000: w_binv = (id_opcode == c_opc_r) && id_funct7_5;
          3'b111: w_op = c_alu_and;
          3'b110: w_op = c_alu_or;
          3'b010: begin
            w_binv = 1'b1;
            w_op   = c_alu_less;
          end
          default: begin
            w_ill     = 1'b1;
            w_wr      = 1'b0;
            w_use_imm = 1'b0;
          end
        endcase
      end
      c_opc_load: begin
        w_use_imm = 1'b1;
        w_wr      = 1'b1;
      end
      c_opc_store: w_use_imm = 1'b1;
      c_opc_branch: begin
        w_binv = 1'b1;
        w_br   = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    valid_d      = valid_q;
    a_d          = a_q;
    b_d          = b_q;
    ainvert_d    = ainvert_q;
    binvert_d    = binvert_q;
    operation_d  = operation_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    is_branch_d  = is_branch_q;
    illegal_d    = illegal_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      is_branch_d = 1'b0;
      illegal_d   = 1'b0;
      if (valid_q && (bubble_cnt_q != c_cnt_max)) begin
        bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
    end else if (!stall) begin
      valid_d     = id_valid;
      a_d         = id_rs1_data;
      b_d         = w_use_imm ? id_imm : id_rs2_data;
      ainvert_d   = 1'b0;
      binvert_d   = w_binv;
      operation_d = w_op;
      rd_d        = id_rd;
      // x0 is hard-wired, so a write to it is never a real write.
      reg_write_d = id_valid && w_wr && (id_rd != '0);
      is_branch_d = id_valid && w_br;
      illegal_d   = id_valid && w_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      ainvert_q    <= 1'b0;
      binvert_q    <= 1'b0;
      operation_q  <= 2'b00;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      is_branch_q  <= 1'b0;
      illegal_q    <= 1'b0;
      bubble_cnt_q <= 16'd0;
    end else begin
      valid_q      <= valid_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ainvert_q    <= ainvert_d;
      binvert_q    <= binvert_d;
      operation_q  <= operation_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      is_branch_q  <= is_branch_d;
      illegal_q    <= illegal_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_a          = a_q;
  assign ex_b          = b_q;
  assign ex_ainvert    = ainvert_q;
  assign ex_binvert    = binvert_q;
  assign ex_operation  = operation_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_is_branch  = is_branch_q;
  assign ex_illegal    = illegal_q;
  assign ex_bubble_cnt = bubble_cnt_q;

endmodule

`default_nettype wire

// File: doc/id_ex_alu_stage.md
Name: id_ex_alu_stage

Overview:
- ID/EX pipeline register and ALU-control decoder for the RV32 core.
- Captures decoded instruction fields and operands at the end of ID.
- Registers the per-slice ALU control (Ainvert, Binvert, Operation) and selected operands so the 32-slice ripple ALU in EX sees stable inputs for a full cycle.
- Supports stall (hold), flush (bubble insert) and flags unsupported ALU ops.

Parameters:
- XLEN, 32, operand/immediate width
- REG_ADDR_W, 5, destination register index width

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID stage holds a valid instruction
- id_opcode  input  7  instruction[6:0]
- id_funct3  input  3  instruction[14:12]
- id_funct7_5  input  1  instruction[30]
- id_rs1_data  input  XLEN  register-file read port 1
- id_rs2_data  input  XLEN  register-file read port 2
- id_imm  input  XLEN  sign-extended immediate from ID
- id_rd  input  REG_ADDR_W  destination register
- stall  input  1  hold all EX registers this cycle
- flush  input  1  replace EX contents with a bubble
- ex_valid  output  1  EX holds a valid instruction
- ex_a  output  XLEN  ALU operand A
- ex_b  output  XLEN  ALU operand B (rs2 or immediate)
- ex_ainvert  output  1  ALU Ainvert, common to all slices
- ex_binvert  output  1  ALU Binvert, also carry-in of slice 0
- ex_operation  output  2  ALU Operation: 00 AND, 01 OR, 10 ADD, 11 LESS
- ex_rd  output  REG_ADDR_W  destination register
- ex_reg_write  output  1  result is written back
- ex_is_branch  output  1  instruction is a conditional branch
- ex_illegal  output  1  opcode/funct not supported by the ALU
- ex_bubble_cnt  output  16  number of bubbles inserted by flush since reset, saturating

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0. ex_operation = 00, ex_bubble_cnt = 0. Deasserting reset takes effect on the next rising edge.
- Latency is one cycle: ID values sampled at edge N appear on ex_* after edge N. There is no combinational path from id_* to ex_*.
- Priority per edge is flush > stall > load.
- Flush:
  - ex_valid, ex_reg_write, ex_is_branch and ex_illegal go to 0. Data outputs may keep old values.
  - ex_bubble_cnt increments by 1 when flush is high and the old ex_valid was 1. It saturates at 0xFFFF.
- Stall (flush low): every register holds, including ex_valid.
- Load: ex_valid <= id_valid. When id_valid = 0, the control flags are loaded as 0.
- Decode, value given as {ainvert, binvert, op}:
  - R-type (0110011):
    - f3 000: f7_5 = 0 gives ADD {0,0,10}; f7_5 = 1 gives SUB {0,1,10}.
    - f3 111: AND {0,0,00}.
    - f3 110: OR {0,0,01}.
    - f3 010: SLT {0,1,11}.
    - ex_b = rs2 and ex_reg_write = 1 for all R-type codes.
  - I-ALU (0010011):
    - f3 000 ADDI, 111 ANDI, 110 ORI, 010 SLTI, with the same codes as R-type.
    - f7_5 is ignored.
    - ex_b = imm, ex_reg_write = 1.
  - Load (0000011): ADD, ex_b = imm, ex_reg_write = 1.
  - Store (0100011): ADD, ex_b = imm, ex_reg_write = 0.
  - Branch (1100011): SUB {0,1,10}, ex_b = rs2, ex_is_branch = 1, ex_reg_write = 0.
  - Anything else, including R/I funct3 values 001, 011, 100 and 101: ex_illegal = 1, ADD code, ex_reg_write = 0, ex_b = rs2.
- ex_a = rs1 for all cases.
- When ex_rd = 0, ex_reg_write is forced to 0.
- flush and stall asserted together behaves as flush.
- Reset mid-stall clears everything. Stall is not remembered after reset.

Test Plan:
- Reset with rst_n low asynchronously mid-cycle, with ex_valid = 1 beforehand -> all outputs read 0 immediately, without waiting for a clock edge.
- R-type SUB (op 0110011, f3 000, f7_5 1), rs1 = 7, rs2 = 9, rd = 3 -> one cycle later ex_a = 7, ex_b = 9, {ainv, binv, op} = {0,1,10}, ex_reg_write = 1.
- ADDI with imm = 0xFFFFFFFC, rd = 0 -> ex_b = 0xFFFFFFFC, op = 10, ex_reg_write = 0 because rd = 0.
- SLT followed by a stall for 3 cycles while ID presents a new OR -> ex_* holds the SLT values {0,1,11} for 3 cycles, then shows OR {0,0,01}.
- Branch loaded, then flush and stall both high -> ex_valid = 0, ex_is_branch = 0, ex_bubble_cnt goes from 0 to 1. A second flush while ex_valid = 0 -> count stays at 1.
- XOR (R-type, f3 100) -> ex_illegal = 1, ex_reg_write = 0, ADD code {0,0,10}. Preload ex_bubble_cnt to 0xFFFF and flush -> count stays at 0xFFFF.
